// File: rtl/pokey_audio_channel.sv
// One POKEY audio channel: tick-gated divider, poly noise gating and volume output.
// Define POKEY_HIPASS_EN to build the high-pass latch clocked by the partner borrow (hp_pulse).
module pokey_audio_channel #(
  parameter int unsigned COUNT_W = 8,
  parameter int unsigned VOL_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable_tick,
  input  logic               stimer,
  input  logic [COUNT_W-1:0] audf,
  input  logic [7:0]         audc,
  input  logic               poly4_bit,
  input  logic               poly5_bit,
  input  logic               poly17_bit,
  input  logic               hp_pulse,
  output logic               borrow_out,
  output logic               channel_out,
  output logic [VOL_W-1:0]   volume_out
);

  logic [COUNT_W-1:0] count_q, count_d;
  logic               chan_q, chan_d;
  logic               borrow_q, borrow_d;
  logic [VOL_W-1:0]   vol_q, vol_d;
  logic [VOL_W-1:0]   vol_level;
  logic               out_eff;
  logic               gate_open;
  logic               noise_bit;

  assign vol_level = VOL_W'(audc[3:0]);
  assign gate_open = audc[7] | poly5_bit;
  assign noise_bit = audc[6] ? poly4_bit : poly17_bit;

  always_comb begin
    count_d  = count_q;
    chan_d   = chan_q;
    borrow_d = 1'b0;
    if (stimer) begin
      count_d = audf;
      chan_d  = 1'b0;
    end else if (enable_tick) begin
      if (count_q == '0) begin
        // Underflow: reload from the current audf so edits only land here.
        count_d  = audf;
        borrow_d = 1'b1;
        if (gate_open) begin
          chan_d = audc[5] ? ~chan_q : noise_bit;
        end
      end else begin
        count_d = count_q - COUNT_W'(1);
      end
    end
  end

`ifdef POKEY_HIPASS_EN
  logic hp_q, hp_d;

  always_comb begin
    hp_d = hp_q;
    if (stimer) begin
      hp_d = 1'b0;
    end else if (hp_pulse) begin
      hp_d = chan_q;
    end
  end

  assign out_eff = chan_d ^ hp_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      hp_q <= 1'b0;
    end else begin
      hp_q <= hp_d;
    end
  end
`else
  logic unused_hp;
  assign unused_hp = hp_pulse;
  assign out_eff   = chan_d;
`endif

  // Volume is computed from next-state values so it moves on the same edge as channel_out.
  always_comb begin
    if (audc[4]) begin
      vol_d = vol_level;
    end else begin
      vol_d = out_eff ? vol_level : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      chan_q   <= 1'b0;
      borrow_q <= 1'b0;
      vol_q    <= '0;
    end else begin
      count_q  <= count_d;
      chan_q   <= chan_d;
      borrow_q <= borrow_d;
      vol_q    <= vol_d;
    end
  end

  assign borrow_out  = borrow_q;
  assign channel_out = chan_q;
  assign volume_out  = vol_q;

endmodule

// File: tb/tb_pokey_audio_channel.sv
// Scoreboard bench for pokey_audio_channel: stimulus pushes expectations, a negedge monitor checks.
module tb_pokey_audio_channel;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable_tick = 1'b0;
  logic       stimer = 1'b0;
  logic [7:0] audf = 8'd0;
  logic [7:0] audc = 8'd0;
  logic       poly4_bit = 1'b0;
  logic       poly5_bit = 1'b0;
  logic       poly17_bit = 1'b0;
  logic       hp_pulse = 1'b0;
  logic       borrow_out;
  logic       channel_out;
  logic [3:0] volume_out;

  pokey_audio_channel #(
    .COUNT_W(8),
    .VOL_W  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable_tick(enable_tick),
    .stimer     (stimer),
    .audf       (audf),
    .audc       (audc),
    .poly4_bit  (poly4_bit),
    .poly5_bit  (poly5_bit),
    .poly17_bit (poly17_bit),
    .hp_pulse   (hp_pulse),
    .borrow_out (borrow_out),
    .channel_out(channel_out),
    .volume_out (volume_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic       b;
    logic       c;
    logic [3:0] v;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // Monitor: compare every expectation whose due cycle has arrived.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (e.due < cyc) begin
        bad++;
        $display("FAIL %s: check missed its cycle (due %0d, now %0d)", e.nm, e.due, cyc);
      end else if ({borrow_out, channel_out, volume_out} !== {e.b, e.c, e.v}) begin
        bad++;
        $display("FAIL %s @%0d: got borrow=%b chan=%b vol=%h, want borrow=%b chan=%b vol=%h",
                 e.nm, cyc, borrow_out, channel_out, volume_out, e.b, e.c, e.v);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic d(input logic r, input logic tk, input logic st, input logic [7:0] f,
                   input logic [7:0] c, input logic [2:0] p, input logic hp,
                   input logic eb, input logic ec, input logic [3:0] ev, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset       = r;
    enable_tick = tk;
    stimer      = st;
    audf        = f;
    audc        = c;
    poly4_bit   = p[2];
    poly5_bit   = p[1];
    poly17_bit  = p[0];
    hp_pulse    = hp;
    e.due = cyc + 1;
    e.b   = eb;
    e.c   = ec;
    e.v   = ev;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  initial begin
    // Reset
    d(1, 0, 0, 8'd0, 8'h00, 3'b000, 0, 0, 0, 4'h0, "reset0");
    d(1, 0, 0, 8'd0, 8'h00, 3'b000, 0, 0, 0, 4'h0, "reset1");

    // Pure tone, audf=3: borrow every 4 ticks, volume follows channel
    for (int i = 0; i < 8; i++) begin
      d(0, 1, 0, 8'd3, 8'hAF, 3'b000, 0, (i % 4) == 0, i < 4, (i < 4) ? 4'hF : 4'h0, "tone");
    end

    // Volume only: constant 5 regardless of channel/borrow/poly
    d(0, 1, 0, 8'd3, 8'h15, 3'b000, 0, 1, 0, 4'h5, "volonly_b");
    d(0, 1, 0, 8'd3, 8'h15, 3'b111, 0, 0, 0, 4'h5, "volonly_1");
    d(0, 1, 0, 8'd3, 8'h15, 3'b010, 0, 0, 0, 4'h5, "volonly_2");
    d(0, 1, 0, 8'd3, 8'h15, 3'b101, 0, 0, 0, 4'h5, "volonly_3");
    d(0, 1, 0, 8'd3, 8'h15, 3'b011, 0, 1, 1, 4'h5, "volonly_p17");
    d(0, 1, 0, 8'd3, 8'h15, 3'b100, 0, 0, 1, 4'h5, "volonly_5");

    // Poly5 gate closed then open
    d(0, 1, 0, 8'd3, 8'h2F, 3'b000, 0, 0, 1, 4'hF, "gate_c1");
    d(0, 1, 0, 8'd3, 8'h2F, 3'b000, 0, 0, 1, 4'hF, "gate_c0");
    d(0, 1, 0, 8'd3, 8'h2F, 3'b000, 0, 1, 1, 4'hF, "gate_held");
    for (int i = 0; i < 3; i++) d(0, 1, 0, 8'd3, 8'h2F, 3'b000, 0, 0, 1, 4'hF, "gate_run");
    d(0, 1, 0, 8'd3, 8'h2F, 3'b010, 0, 1, 0, 4'h0, "gate_open");

    // audf edit lands only at next reload; then stimer/tick collision at count 0
    for (int i = 0; i < 3; i++) d(0, 1, 0, 8'd7, 8'hAF, 3'b000, 0, 0, 0, 4'h0, "inflight");
    d(0, 1, 0, 8'd7, 8'hAF, 3'b000, 0, 1, 1, 4'hF, "reload7");
    for (int i = 0; i < 7; i++) d(0, 1, 0, 8'd7, 8'hAF, 3'b000, 0, 0, 1, 4'hF, "run7");
    d(0, 1, 1, 8'd7, 8'hAF, 3'b000, 0, 0, 0, 4'h0, "collision");
    for (int i = 0; i < 7; i++) d(0, 1, 0, 8'd7, 8'hAF, 3'b000, 0, 0, 0, 4'h0, "post_coll");
    d(0, 1, 0, 8'd7, 8'hAF, 3'b000, 0, 1, 1, 4'hF, "coll_borrow");

    // Reset mid-period at count=100 with audf=200
    for (int i = 0; i < 7; i++) d(0, 1, 0, 8'd200, 8'h8F, 3'b000, 0, 0, 1, 4'hF, "pre200");
    d(0, 1, 0, 8'd200, 8'h8F, 3'b001, 0, 1, 1, 4'hF, "noise_p17");
    for (int i = 0; i < 100; i++) d(0, 1, 0, 8'd200, 8'h8F, 3'b000, 0, 0, 1, 4'hF, "run200");
    d(1, 1, 0, 8'd200, 8'h8F, 3'b000, 0, 0, 0, 4'h0, "mid_reset");
    d(0, 0, 0, 8'd200, 8'h8F, 3'b000, 0, 0, 0, 4'h0, "post_reset");
    d(0, 1, 0, 8'd200, 8'h8F, 3'b001, 0, 1, 1, 4'hF, "first_tick");

    // High-pass latch (ignored unless built in)
    d(0, 0, 1, 8'd1, 8'hAF, 3'b000, 0, 0, 0, 4'h0, "hp_stimer");
    d(0, 1, 0, 8'd1, 8'hAF, 3'b000, 0, 0, 0, 4'h0, "hp_run");
    d(0, 1, 0, 8'd1, 8'hAF, 3'b000, 0, 1, 1, 4'hF, "hp_toggle1");
`ifdef POKEY_HIPASS_EN
    d(0, 1, 0, 8'd1, 8'hAF, 3'b000, 1, 0, 1, 4'h0, "hp_latch");
    d(0, 1, 0, 8'd1, 8'hAF, 3'b000, 0, 1, 0, 4'hF, "hp_toggle2");
`else
    d(0, 1, 0, 8'd1, 8'hAF, 3'b000, 1, 0, 1, 4'hF, "hp_ignored");
    d(0, 1, 0, 8'd1, 8'hAF, 3'b000, 0, 1, 0, 4'h0, "hp_toggle2");
`endif

    // audf=0: underflow and toggle every tick; borrow drops without a tick
    d(0, 0, 1, 8'd0, 8'hAF, 3'b000, 0, 0, 0, 4'h0, "f0_stimer");
    d(0, 1, 0, 8'd0, 8'hAF, 3'b000, 0, 1, 1, 4'hF, "f0_t1");
    d(0, 1, 0, 8'd0, 8'hAF, 3'b000, 0, 1, 0, 4'h0, "f0_t2");
    d(0, 1, 0, 8'd0, 8'hAF, 3'b000, 0, 1, 1, 4'hF, "f0_t3");
    d(0, 0, 0, 8'd0, 8'hAF, 3'b000, 0, 0, 1, 4'hF, "f0_idle");

    // audf=max: 256-tick period
    d(0, 0, 1, 8'd255, 8'hAF, 3'b000, 0, 0, 0, 4'h0, "fmax_stimer");
    for (int i = 0; i < 255; i++) d(0, 1, 0, 8'd255, 8'hAF, 3'b000, 0, 0, 0, 4'h0, "fmax_run");
    d(0, 1, 0, 8'd255, 8'hAF, 3'b000, 0, 1, 1, 4'hF, "fmax_borrow");

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL %s: never checked (due %0d)", e.nm, e.due);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
